rlwe_mprf_wb_sched: RTL and testbench

Write-back scheduler for the RLWE multi-port register file (MPRF). It shares the MPRF's single write port between the EXU write-back path and a vector-load assembler. The assembler collects `LANES` scalar words from the LSU into one full vector, then writes that vector to a vector register. The block sits between the EXU/LSU and the MPRF write interface and drives that interface directly.

---
 rtl/rlwe_mprf_wb_sched_if.sv | 49 ++++
 rtl/rlwe_mprf_wb_sched.sv | 103 ++++++++++
 tb/tb_rlwe_mprf_wb_sched.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rlwe_mprf_wb_sched_if.sv
// Bundle of the EXU write-back, vector-load (LSU) and MPRF write-port signals
// around the write-back scheduler.
interface rlwe_mprf_wb_sched_if #(
  parameter int LANES = 4,
  parameter int XLEN  = 32,
  parameter int AW    = 5
);
  // Handshakes: vld_start transfers when vld_start && vld_start_ready, a word
  // transfers when vld_word_valid && vld_word_ready (the LSU holds an unaccepted
  // word); exu_w_req is never back-pressured except via exu_stall one cycle ahead.
  logic                  exu_w_req;
  logic [AW-1:0]         exu_rd_addr;
  logic                  exu_rd_is_vector;
  logic [LANES*XLEN-1:0] exu_rd_data;

  logic                  vld_start;
  logic [AW-1:0]         vld_rd_addr;
  logic                  vld_start_ready;
  logic                  vld_word_valid;
  logic [XLEN-1:0]       vld_word_data;
  logic                  vld_word_ready;
  logic                  vld_done;
  logic                  vld_busy;
  logic [AW-1:0]         vld_busy_addr;

  logic                  exu_stall;
  logic                  mprf_w_req;
  logic [AW-1:0]         mprf_rd_addr;
  logic                  mprf_rd_is_vector;
  logic [LANES*XLEN-1:0] mprf_rd_data;

  logic [1:0]            dbg_state;

  modport master (
    output exu_w_req, exu_rd_addr, exu_rd_is_vector, exu_rd_data,
    output vld_start, vld_rd_addr, vld_word_valid, vld_word_data,
    input  vld_start_ready, vld_word_ready, vld_done, vld_busy, vld_busy_addr,
    input  exu_stall, mprf_w_req, mprf_rd_addr, mprf_rd_is_vector, mprf_rd_data,
    input  dbg_state
  );

  modport slave (
    input  exu_w_req, exu_rd_addr, exu_rd_is_vector, exu_rd_data,
    input  vld_start, vld_rd_addr, vld_word_valid, vld_word_data,
    output vld_start_ready, vld_word_ready, vld_done, vld_busy, vld_busy_addr,
    output exu_stall, mprf_w_req, mprf_rd_addr, mprf_rd_is_vector, mprf_rd_data,
    output dbg_state
  );
endinterface

// File: rtl/rlwe_mprf_wb_sched.sv
// Shares the MPRF write port between EXU write-back and a vector-load assembler
// that gathers LANES scalar LSU words into one vector register write.
module rlwe_mprf_wb_sched #(
  parameter int LANES     = 4,
  parameter int XLEN      = 32,
  parameter int AW        = 5,
  parameter int MAX_DEFER = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rlwe_mprf_wb_sched_if.slave  wb_if
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int DW = $clog2(MAX_DEFER + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  state_e                          state_q;
  logic [LANES-1:0][XLEN-1:0]      buf_q;
  logic [CW-1:0]                   lane_q;
  logic [AW-1:0]                   addr_q;
  logic [DW-1:0]                   defer_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      lane_q  <= '0;
      addr_q  <= '0;
      defer_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wb_if.vld_start) begin
            addr_q  <= wb_if.vld_rd_addr;
            lane_q  <= '0;
            state_q <= S_FILL;
          end
        end
        S_FILL: begin
          if (wb_if.vld_word_valid) begin
            buf_q[lane_q] <= wb_if.vld_word_data;
            if (lane_q == CW'(LANES - 1)) begin
              lane_q  <= '0;
              state_q <= S_WRITE;
            end else begin
              lane_q <= lane_q + 1'b1;
            end
          end
        end
        S_WRITE: begin
          // The EXU always wins the port; the vector write waits for a free cycle.
          if (wb_if.exu_w_req) begin
            if (defer_q < DW'(MAX_DEFER)) defer_q <= defer_q + 1'b1;
          end else begin
            defer_q <= '0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb_if.dbg_state       = state_q;
  assign wb_if.vld_start_ready = (state_q == S_IDLE);
  assign wb_if.vld_word_ready  = (state_q == S_FILL);
  assign wb_if.vld_busy        = (state_q != S_IDLE);
  assign wb_if.vld_busy_addr   = (state_q != S_IDLE) ? addr_q : '0;
  assign wb_if.exu_stall       = (state_q == S_WRITE) && (defer_q >= DW'(MAX_DEFER));
  assign wb_if.vld_done        = (state_q == S_WRITE) && !wb_if.exu_w_req;

  // A load to register 0 still retires, but never raises the write request.
  always_comb begin
    wb_if.mprf_w_req        = 1'b0;
    wb_if.mprf_rd_addr      = '0;
    wb_if.mprf_rd_is_vector = 1'b0;
    wb_if.mprf_rd_data      = '0;
    if (wb_if.exu_w_req) begin
      wb_if.mprf_w_req        = 1'b1;
      wb_if.mprf_rd_addr      = wb_if.exu_rd_addr;
      wb_if.mprf_rd_is_vector = wb_if.exu_rd_is_vector;
      wb_if.mprf_rd_data      = wb_if.exu_rd_data;
    end else if (state_q == S_WRITE) begin
      wb_if.mprf_w_req        = (addr_q != '0);
      wb_if.mprf_rd_addr      = addr_q;
      wb_if.mprf_rd_is_vector = 1'b1;
      wb_if.mprf_rd_data      = buf_q;
    end
  end

`ifndef SYNTHESIS
  a_no_exu_while_stalled: assert property (
    @(posedge clk) disable iff (!rst_n) !(wb_if.exu_stall && wb_if.exu_w_req)
  );
`endif

endmodule

// File: tb/tb_rlwe_mprf_wb_sched.sv
// Bench for rlwe_mprf_wb_sched: EXU pass-through table, vector loads with gaps,
// destination 0, EXU deferral/stall and mid-load reset.
module tb_rlwe_mprf_wb_sched;
  localparam int LANES     = 4;
  localparam int XLEN      = 32;
  localparam int AW        = 5;
  localparam int MAX_DEFER = 4;
  localparam int VW        = LANES * XLEN;
  localparam int W         = AW + 1 + VW;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [W-1:0] exp_q[$];

  rlwe_mprf_wb_sched_if #(.LANES(LANES), .XLEN(XLEN), .AW(AW)) wb ();

  rlwe_mprf_wb_sched #(.LANES(LANES), .XLEN(XLEN), .AW(AW), .MAX_DEFER(MAX_DEFER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb_if (wb)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / check tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wb.exu_w_req        = 1'b0;
    wb.exu_rd_addr      = '0;
    wb.exu_rd_is_vector = 1'b0;
    wb.exu_rd_data      = '0;
    wb.vld_start        = 1'b0;
    wb.vld_rd_addr      = '0;
    wb.vld_word_valid   = 1'b0;
    wb.vld_word_data    = '0;
  endtask

  task automatic exu_drive(input logic [AW-1:0] a, input logic [VW-1:0] d);
    wb.exu_w_req        = 1'b1;
    wb.exu_rd_addr      = a;
    wb.exu_rd_is_vector = 1'b0;
    wb.exu_rd_data      = d;
    exp_q.push_back({a, 1'b0, d});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start_ready"}, wb.vld_start_ready, 1);
    chk({tag, "_word_ready"},  wb.vld_word_ready, 0);
    chk({tag, "_done"},        wb.vld_done, 0);
    chk({tag, "_busy"},        wb.vld_busy, 0);
    chk({tag, "_busy_addr"},   wb.vld_busy_addr, 0);
    chk({tag, "_stall"},       wb.exu_stall, 0);
    chk({tag, "_w_req"},       wb.mprf_w_req, 0);
    chk({tag, "_addr"},        wb.mprf_rd_addr, 0);
    chk({tag, "_data"},        wb.mprf_rd_data, 0);
  endtask

  // Full load: start, LANES words (optional gap before lane 2), write cycle.
  task automatic do_load(input logic [AW-1:0] a, input logic [VW-1:0] wv,
                         input int gap, input logic expect_wr);
    wb.vld_start   = 1'b1;
    wb.vld_rd_addr = a;
    neg();
    chk("start_ready", wb.vld_start_ready, 1);
    step();
    wb.vld_start   = 1'b0;
    wb.vld_rd_addr = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i == 2) begin
        for (int g = 0; g < gap; g++) begin
          wb.vld_word_valid = 1'b0;
          wb.vld_word_data  = 32'hDEAD_BEEF;
          neg();
          chk("gap_word_ready", wb.vld_word_ready, 1);
          step();
        end
      end
      wb.vld_word_valid = 1'b1;
      wb.vld_word_data  = wv[i*XLEN +: XLEN];
      neg();
      chk("fill_word_ready", wb.vld_word_ready, 1);
      chk("fill_busy_addr", wb.vld_busy_addr, a);
      chk("fill_done", wb.vld_done, 0);
      step();
    end
    wb.vld_word_valid = 1'b0;
    wb.vld_word_data  = '0;
    if (expect_wr) exp_q.push_back({a, 1'b1, wv});
    neg();
    chk("write_done", wb.vld_done, 1);
    chk("write_w_req", wb.mprf_w_req, expect_wr);
    chk("write_busy", wb.vld_busy, 1);
    chk("write_start_ready", wb.vld_start_ready, 0);
    step();
    neg();
    chk("after_done", wb.vld_done, 0);
    chk("after_start_ready", wb.vld_start_ready, 1);
    chk("after_busy", wb.vld_busy, 0);
    chk("after_busy_addr", wb.vld_busy_addr, 0);
    step();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && wb.mprf_w_req) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got %0h want none",
                 {wb.mprf_rd_addr, wb.mprf_rd_is_vector, wb.mprf_rd_data});
      end else begin
        chk("mprf_write", {wb.mprf_rd_addr, wb.mprf_rd_is_vector, wb.mprf_rd_data},
            exp_q.pop_front());
      end
    end
  end

  // ---------------- EXU pass-through table ----------------
  typedef struct {
    logic          req;
    logic [AW-1:0] addr;
    logic          vec;
    logic [VW-1:0] data;
    logic          exp_req;
    logic [AW-1:0] exp_addr;
    logic          exp_vec;
    logic [VW-1:0] exp_data;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [VW-1:0] vdat;
    vdat = {32'hA4A4_0004, 32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001};
    tbl[0] = '{1'b1, 5'd3,  1'b0, 128'hABCD, 1'b1, 5'd3,  1'b0, 128'hABCD};
    tbl[1] = '{1'b1, 5'd7,  1'b1, vdat,      1'b1, 5'd7,  1'b1, vdat};
    tbl[2] = '{1'b1, 5'd0,  1'b0, 128'h55,   1'b1, 5'd0,  1'b0, 128'h55};
    tbl[3] = '{1'b0, 5'd9,  1'b1, 128'hFFFF, 1'b0, 5'd0,  1'b0, 128'h0};
    tbl[4] = '{1'b1, 5'd31, 1'b1, {VW{1'b1}}, 1'b1, 5'd31, 1'b1, {VW{1'b1}}};

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    neg();
    check_reset_outputs("reset");
    step();
    rst_n = 1'b1;
    step();
    neg();
    check_reset_outputs("post_reset");
    step();

    for (int i = 0; i < 5; i++) begin
      wb.exu_w_req        = tbl[i].req;
      wb.exu_rd_addr      = tbl[i].addr;
      wb.exu_rd_is_vector = tbl[i].vec;
      wb.exu_rd_data      = tbl[i].data;
      if (tbl[i].exp_req) exp_q.push_back({tbl[i].exp_addr, tbl[i].exp_vec, tbl[i].exp_data});
      neg();
      chk("tbl_w_req", wb.mprf_w_req, tbl[i].exp_req);
      chk("tbl_addr", wb.mprf_rd_addr, tbl[i].exp_addr);
      chk("tbl_vec", wb.mprf_rd_is_vector, tbl[i].exp_vec);
      chk("tbl_data", wb.mprf_rd_data, tbl[i].exp_data);
      chk("tbl_busy", wb.vld_busy, 0);
      step();
    end
    idle_inputs();

    // Basic back-to-back load to v5.
    do_load(5'd5, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 1'b1);

    // Stray word in IDLE is ignored, then a load with a 2-cycle gap.
    wb.vld_word_valid = 1'b1;
    wb.vld_word_data  = 32'hBAD0_BAD0;
    neg();
    chk("idle_word_ready", wb.vld_word_ready, 0);
    step();
    wb.vld_word_valid = 1'b0;
    do_load(5'd12, {32'hC0DE_0004, 32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001}, 2, 1'b1);

    // Destination 0: retires without a write request.
    do_load(5'd0, {32'h4, 32'h3, 32'h2, 32'h1}, 0, 1'b0);

    // EXU holds the port for 6 cycles, the last 4 of them in WRITE.
    wb.vld_start   = 1'b1;
    wb.vld_rd_addr = 5'd9;
    step();
    wb.vld_start   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      wb.vld_word_valid = 1'b1;
      wb.vld_word_data  = 32'h9000_0000 + 32'(i);
      if (i >= 2) exu_drive(5'(i + 1), 128'(32'h7700 + i));
      neg();
      chk("defer_fill_stall", wb.exu_stall, 0);
      step();
    end
    wb.vld_word_valid = 1'b0;
    for (int k = 0; k < MAX_DEFER; k++) begin
      exu_drive(5'(k + 20), 128'(32'h8800 + k));
      neg();
      chk("defer_stall_low", wb.exu_stall, 0);
      chk("defer_done_low", wb.vld_done, 0);
      chk("defer_busy", wb.vld_busy, 1);
      step();
    end
    idle_inputs();
    exp_q.push_back({5'd9, 1'b1, 32'h9000_0003, 32'h9000_0002, 32'h9000_0001, 32'h9000_0000});
    neg();
    chk("defer_stall_high", wb.exu_stall, 1);
    chk("defer_done", wb.vld_done, 1);
    chk("defer_w_req", wb.mprf_w_req, 1);
    step();
    neg();
    chk("defer_stall_clear", wb.exu_stall, 0);
    chk("defer_done_clear", wb.vld_done, 0);
    step();

    // Reset after 2 of 4 words abandons the load.
    wb.vld_start   = 1'b1;
    wb.vld_rd_addr = 5'd6;
    step();
    wb.vld_start   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wb.vld_word_valid = 1'b1;
      wb.vld_word_data  = 32'h6600 + 32'(i);
      step();
    end
    wb.vld_word_valid = 1'b0;
    rst_n = 1'b0;
    neg();
    check_reset_outputs("midload_reset");
    step();
    rst_n = 1'b1;
    step();
    neg();
    check_reset_outputs("after_midload");
    step();
    do_load(5'd6, {32'h6604, 32'h6603, 32'h6602, 32'h6601}, 0, 1'b1);

    repeat (2) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
